// File: rtl/note_judge.sv
// Rhythm-game judgement stage: four per-lane note FIFOs, a per-frame lane scan
// that grades the oldest note of each lane, and combo/score bookkeeping.

module note_lane_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] din,
  output logic [15:0] head,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;

  assign head  = mem[rptr];
  // DEPTH is a power of two, so the count MSB alone means "full".
  assign full  = cnt[AW];
  assign empty = (cnt == '0);
endmodule

module note_judge #(
  parameter int DEPTH       = 16,
  parameter int PERFECT_WIN = 2,
  parameter int GREAT_WIN   = 5,
  parameter int PERFECT_PTS = 300,
  parameter int GREAT_PTS   = 100
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        new_frame,
  input  logic [15:0] un_time,
  input  logic [3:0]  DFJK,
  input  logic        note_wr,
  input  logic [1:0]  note_lane,
  input  logic [15:0] note_time,
  output logic [3:0]  note_full,
  output logic [3:0]  lane_empty,
  output logic        overflow,
  output logic        busy,
  output logic        judge_valid,
  output logic [1:0]  judge_lane,
  output logic [1:0]  judge_kind,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo,
  output logic [19:0] score
);
  localparam int NUM_LANES = 4;
  localparam logic signed [16:0] PW = 17'(PERFECT_WIN);
  localparam logic signed [16:0] GW = 17'(GREAT_WIN);
  localparam logic [20:0] PP = 21'(PERFECT_PTS);
  localparam logic [20:0] GP = 21'(GREAT_PTS);

  typedef enum logic [2:0] {IDLE, CAP, SCAN0, SCAN1, SCAN2, SCAN3} state_t;
  state_t state, state_nx;

  logic [15:0]                      t_cap;
  logic [3:0]                       press, prev_dfjk;
  logic [NUM_LANES-1:0][15:0]       head;
  logic [NUM_LANES-1:0]             push, pop;
  logic [1:0]                       lane, kind;
  logic                             scanning;
  logic signed [16:0]               d, ad;
  logic [20:0]                      add, sum;
  logic [19:0]                      score_nx;
  logic [9:0]                       combo_nx, max_nx;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    // A full lane still accepts a write when its head leaves in the same cycle.
    assign push[i] = note_wr && (note_lane == 2'(i)) && (!note_full[i] || pop[i]);
    assign pop[i]  = (kind != 2'd0) && (lane == 2'(i));
    note_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (note_time),
      .head    (head[i]),
      .full    (note_full[i]),
      .empty   (lane_empty[i])
    );
  end

  always_comb begin
    state_nx = state;
    scanning = 1'b1;
    lane     = 2'd0;
    case (state)
      IDLE:    begin scanning = 1'b0; if (new_frame) state_nx = CAP; end
      CAP:     begin scanning = 1'b0; state_nx = SCAN0; end
      SCAN0:   begin lane = 2'd0; state_nx = SCAN1; end
      SCAN1:   begin lane = 2'd1; state_nx = SCAN2; end
      SCAN2:   begin lane = 2'd2; state_nx = SCAN3; end
      SCAN3:   begin lane = 2'd3; state_nx = IDLE;  end
      default: begin scanning = 1'b0; state_nx = IDLE; end
    endcase
  end

  // Grade the scanned lane: 0 = no action, 1 = perfect, 2 = great, 3 = miss.
  always_comb begin
    d    = $signed({1'b0, t_cap}) - $signed({1'b0, head[lane]});
    ad   = d[16] ? -d : d;
    kind = 2'd0;
    if (scanning && !lane_empty[lane]) begin
      if (d > GW)                        kind = 2'd3;
      else if (press[lane] && ad <= PW)  kind = 2'd1;
      else if (press[lane] && ad <= GW)  kind = 2'd2;
    end
  end

  always_comb begin
    add      = (kind == 2'd1) ? PP : (kind == 2'd2) ? GP : '0;
    sum      = {1'b0, score} + add;
    score_nx = sum[20] ? 20'hFFFFF : sum[19:0];
    if (kind == 2'd3)            combo_nx = '0;
    else if (combo == 10'h3FF)   combo_nx = combo;
    else                         combo_nx = combo + 1'b1;
    max_nx   = (combo_nx > max_combo) ? combo_nx : max_combo;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      t_cap       <= '0;
      press       <= '0;
      prev_dfjk   <= '0;
      overflow    <= 1'b0;
      judge_valid <= 1'b0;
      judge_lane  <= '0;
      judge_kind  <= '0;
      combo       <= '0;
      max_combo   <= '0;
      score       <= '0;
    end else begin
      state       <= state_nx;
      judge_valid <= (kind != 2'd0);
      if (state == CAP) begin
        t_cap     <= un_time;
        press     <= DFJK & ~prev_dfjk;
        prev_dfjk <= DFJK;
      end
      if (note_wr && note_full[note_lane] && !pop[note_lane]) overflow <= 1'b1;
      if (kind != 2'd0) begin
        judge_lane <= lane;
        judge_kind <= kind;
        score      <= score_nx;
        combo      <= combo_nx;
        max_combo  <= max_nx;
      end
    end
  end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_note_judge.sv
// Bench for note_judge: directed vector table, hand-written corner sequences and
// random frames checked against a queue-based scoring model.

module tb_note_judge;
  localparam int PW = 2, GW = 5, PPTS = 300, GPTS = 100;

  logic        clk = 0, reset_n = 0, new_frame = 0, note_wr = 0;
  logic [15:0] un_time = 0, note_time = 0;
  logic [3:0]  DFJK = 0;
  logic [1:0]  note_lane = 0;
  logic [3:0]  note_full, lane_empty;
  logic        overflow, busy, judge_valid;
  logic [1:0]  judge_lane, judge_kind;
  logic [9:0]  combo, max_combo;
  logic [19:0] score;

  note_judge dut (
    .clk(clk), .reset_n(reset_n), .new_frame(new_frame), .un_time(un_time), .DFJK(DFJK),
    .note_wr(note_wr), .note_lane(note_lane), .note_time(note_time),
    .note_full(note_full), .lane_empty(lane_empty), .overflow(overflow), .busy(busy),
    .judge_valid(judge_valid), .judge_lane(judge_lane), .judge_kind(judge_kind),
    .combo(combo), .max_combo(max_combo), .score(score)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int q[4][$];
  int m_score, m_combo, m_max;
  bit m_ovf;
  logic [3:0] m_prev;

  typedef struct {
    int lane; int h; int t; logic [3:0] keys; int kind; int sc;
  } vec_t;
  vec_t tbl[12];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) q[i].delete();
    m_score = 0; m_combo = 0; m_max = 0; m_ovf = 0; m_prev = 0;
  endfunction

  function automatic void m_push(input int l, input int tm);
    if (q[l].size() < 16) q[l].push_back(tm); else m_ovf = 1;
  endfunction

  task automatic check_flags();
    for (int i = 0; i < 4; i++) begin
      chk("note_full", note_full[i], q[i].size() == 16);
      chk("lane_empty", lane_empty[i], q[i].size() == 0);
    end
    chk("overflow", overflow, m_ovf);
  endtask

  task automatic check_reset_outs();
    chk("rst_full", note_full, 0);   chk("rst_empty", lane_empty, 15);
    chk("rst_ovf", overflow, 0);     chk("rst_busy", busy, 0);
    chk("rst_jv", judge_valid, 0);   chk("rst_jl", judge_lane, 0);
    chk("rst_jk", judge_kind, 0);    chk("rst_combo", combo, 0);
    chk("rst_max", max_combo, 0);    chk("rst_score", score, 0);
  endtask

  task automatic do_reset();
    reset_n = 0; new_frame = 0; note_wr = 0; DFJK = 0;
    tick(); tick();
    reset_n = 1;
    model_reset();
  endtask

  task automatic push(input int l, input int tm);
    note_wr = 1; note_lane = 2'(l); note_time = 16'(tm);
    tick();
    note_wr = 0;
    m_push(l, tm);
    check_flags();
  endtask

  // One full frame; optionally a write during SCAN<push_at> and new_frame held high mid-scan.
  task automatic frame(input int t, input logic [3:0] keys, input int push_at, input int pl,
                       input int pt, input bit hold_nf, output logic [3:0][1:0] got);
    logic [3:0] press;
    int kind, d, ad;
    un_time = 16'(t); DFJK = keys; new_frame = 1;
    tick();
    new_frame = hold_nf;
    chk("busy_cap", busy, 1);
    tick();
    press = keys & ~m_prev;
    m_prev = keys;
    got = '0;
    for (int i = 0; i < 4; i++) begin
      kind = 0;
      if (q[i].size() > 0) begin
        d  = t - q[i][0];
        ad = (d < 0) ? -d : d;
        if (d > GW)                       kind = 3;
        else if (press[i] && ad <= PW)    kind = 1;
        else if (press[i] && ad <= GW)    kind = 2;
      end
      if (kind != 0) begin
        void'(q[i].pop_front());
        if (kind == 3) m_combo = 0;
        else begin
          m_score += (kind == 1) ? PPTS : GPTS;
          if (m_score > 20'hFFFFF) m_score = 20'hFFFFF;
          if (m_combo < 1023) m_combo++;
          if (m_combo > m_max) m_max = m_combo;
        end
      end
      if (push_at == i) begin
        note_wr = 1; note_lane = 2'(pl); note_time = 16'(pt);
        m_push(pl, pt);
      end
      tick();
      note_wr = 0;
      chk("judge_valid", judge_valid, kind != 0);
      if (kind != 0) begin
        chk("judge_lane", judge_lane, i);
        chk("judge_kind", judge_kind, kind);
      end
      if (judge_valid) got[i] = judge_kind;
      chk("score", score, m_score);
      chk("combo", combo, m_combo);
      chk("max_combo", max_combo, m_max);
      chk("busy_scan", busy, i < 3);
    end
    new_frame = 0;
    check_flags();
  endtask

  initial begin
    logic [3:0][1:0] got;
    int cur, pa;

    tbl[0]  = '{0, 100,   101,   4'h1, 1, 300};
    tbl[1]  = '{1, 100,   98,    4'h2, 1, 300};
    tbl[2]  = '{2, 100,   97,    4'h4, 2, 100};
    tbl[3]  = '{3, 100,   105,   4'h8, 2, 100};
    tbl[4]  = '{0, 100,   106,   4'h0, 3, 0};
    tbl[5]  = '{1, 100,   106,   4'h2, 3, 0};
    tbl[6]  = '{2, 100,   94,    4'h4, 0, 0};
    tbl[7]  = '{3, 100,   95,    4'h8, 2, 100};
    tbl[8]  = '{0, 100,   103,   4'h0, 0, 0};
    tbl[9]  = '{1, 65530, 3,     4'h2, 0, 0};
    tbl[10] = '{2, 5,     65535, 4'h0, 3, 0};
    tbl[11] = '{3, 100,   102,   4'h8, 1, 300};

    do_reset();
    check_reset_outs();

    for (int k = 0; k < 12; k++) begin
      do_reset();
      push(tbl[k].lane, tbl[k].h);
      frame(tbl[k].t, tbl[k].keys, -1, 0, 0, 0, got);
      chk("tbl_kind", got[tbl[k].lane], tbl[k].kind);
      chk("tbl_score", score, tbl[k].sc);
    end

    // Great then miss: combo clears, best combo remains.
    do_reset();
    push(2, 50); push(2, 60);
    frame(46, 4'h4, -1, 0, 0, 0, got);
    chk("seq_great", got[2], 2); chk("seq_great_score", score, 100);
    frame(66, 4'h0, -1, 0, 0, 0, got);
    chk("seq_miss", got[2], 3); chk("seq_miss_combo", combo, 0); chk("seq_miss_max", max_combo, 1);

    // Held key gives no rising edge.
    do_reset();
    push(1, 20);
    frame(10, 4'h2, -1, 0, 0, 0, got);
    frame(20, 4'h2, -1, 0, 0, 0, got);
    chk("held_none", got[1], 0);
    frame(26, 4'h2, -1, 0, 0, 0, got);
    chk("held_miss", got[1], 3);

    // All four lanes perfect, with new_frame held high during the scan.
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 30);
    frame(30, 4'hF, -1, 0, 0, 1, got);
    chk("simul_kinds", got, 8'h55); chk("simul_score", score, 1200); chk("simul_combo", combo, 4);

    // Mid-scan pushes into empty lanes: ahead of the scan is seen, at the scan is not.
    do_reset();
    push(0, 40);
    frame(40, 4'hF, 1, 2, 40, 0, got);
    chk("midpush_seen", got[2], 1);
    frame(40, 4'h0, -1, 0, 0, 0, got);
    frame(40, 4'hF, 1, 1, 40, 0, got);
    chk("midpush_unseen", got[1], 0); chk("midpush_kept", lane_empty[1], 0);

    // Overflow, then a push concurrent with a pop on the full lane.
    do_reset();
    for (int k = 0; k < 15; k++) push(3, 200);
    chk("full_15", note_full[3], 0);
    push(3, 200);
    chk("full_16", note_full[3], 1);
    push(3, 200);
    chk("ovf_17", overflow, 1);
    frame(200, 4'h8, 3, 3, 200, 0, got);
    chk("pushpop_kind", got[3], 1); chk("pushpop_full", note_full[3], 1); chk("ovf_sticky", overflow, 1);

    // Reset in the middle of a scan.
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 30);
    un_time = 16'd30; DFJK = 4'hF; new_frame = 1;
    tick(); new_frame = 0;
    tick(); tick();
    chk("rstmid_first", judge_valid, 1);
    reset_n = 0;
    tick();
    check_reset_outs();
    reset_n = 1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rstmid_quiet", judge_valid, 0);
      chk("rstmid_idle", busy, 0);
    end

    // Random frames against the model.
    do_reset();
    cur = 100;
    for (int f = 0; f < 300; f++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) push($urandom_range(0, 3), cur + $urandom_range(0, 10));
      pa = $urandom_range(0, 7);
      if (pa > 3) pa = -1;
      frame(cur, 4'($urandom), pa, $urandom_range(0, 3), cur + $urandom_range(0, 10), 1'($urandom), got);
      cur += $urandom_range(1, 3);
    end

    // Saturation: 4000 perfects.
    do_reset();
    for (int r = 0; r < 1000; r++) begin
      for (int i = 0; i < 4; i++) push(i, 1000);
      frame(1000, 4'hF, -1, 0, 0, 0, got);
      frame(1000, 4'h0, -1, 0, 0, 0, got);
    end
    chk("sat_score", score, 20'hFFFFF); chk("sat_combo", combo, 1023); chk("sat_max", max_combo, 1023);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
